// File: rtl/key_evt_pkg.sv
// Shared types and helpers for the key event encoder: event record,
// default sizes and the round-robin pending-key picker.
package key_evt_pkg;

    localparam int NKEYS_DEF = 8;
    localparam int DEPTH_DEF = 8;
    localparam int KEY_W_DEF = $clog2(NKEYS_DEF);

    typedef struct packed {
        logic                 press;
        logic [KEY_W_DEF-1:0] key;
    } key_evt_t;

    typedef struct packed {
        logic                 valid;
        logic [KEY_W_DEF-1:0] idx;
    } rr_pick_t;

    // Scanning from the far end lets the candidate closest to ptr win last.
    function automatic rr_pick_t rr_pick(input logic [NKEYS_DEF-1:0] pend,
                                         input logic [KEY_W_DEF-1:0] ptr);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int i = NKEYS_DEF - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NKEYS_DEF;
            if (pend[j[KEY_W_DEF-1:0]]) begin
                r.valid = 1'b1;
                r.idx   = j[KEY_W_DEF-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through FIFO of key events with an occupancy count.
module key_evt_fifo
    import key_evt_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  key_evt_t               push_data,
    input  logic                   pop,
    output key_evt_t               head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    key_evt_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            wr_en;
    logic            rd_en;

    assign valid = (count != '0);
    assign wr_en = push && (count != (AW+1)'(DEPTH));
    assign rd_en = pop && valid;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_encoder.sv
// Turns debounced key levels into queued press/release events and
// exports the live held-key mask.
module key_event_encoder
    import key_evt_pkg::*;
#(
    parameter int NKEYS      = NKEYS_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ACTIVE_LOW = 1,
    parameter int KEY_W      = $clog2(NKEYS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NKEYS-1:0]       key_in,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic                   ev_press,
    output logic [KEY_W-1:0]       ev_key,
    output logic [NKEYS-1:0]       key_held,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [NKEYS-1:0] pressed;
    logic [NKEYS-1:0] edges;
    logic [NKEYS-1:0] pend;
    logic [NKEYS-1:0] ptype;
    logic [NKEYS-1:0] pend_nxt;
    logic [NKEYS-1:0] ptype_nxt;
    logic [NKEYS-1:0] svc_mask;
    logic [KEY_W-1:0] rr_ptr;
    logic [KEY_W-1:0] rr_nxt;
    logic             armed;
    logic             cancel;
    logic             push;
    rr_pick_t         pick;
    key_evt_t         push_evt;
    key_evt_t         head;

    assign pressed = (ACTIVE_LOW != 0) ? ~key_in : key_in;
    assign edges   = armed ? (pressed ^ key_held) : '0;

    // Fullness is judged on the count before any same-cycle pop.
    always_comb begin
        pick           = rr_pick(pend, rr_ptr);
        push           = pick.valid && (fifo_count < CW'(DEPTH));
        push_evt.press = ptype[pick.idx];
        push_evt.key   = pick.idx;
        rr_nxt         = rr_ptr;
        svc_mask       = '0;
        if (push) begin
            svc_mask[pick.idx] = 1'b1;
            rr_nxt = (pick.idx == KEY_W'(NKEYS - 1)) ? '0 : pick.idx + KEY_W'(1);
        end
    end

    // A second edge on a still-pending key cancels both events; an edge on
    // a key being serviced this cycle simply re-pends it.
    always_comb begin
        pend_nxt  = pend;
        ptype_nxt = ptype;
        cancel    = 1'b0;
        for (int k = 0; k < NKEYS; k++) begin
            if (edges[k]) begin
                if (pend[k] && !svc_mask[k]) begin
                    pend_nxt[k] = 1'b0;
                    cancel      = 1'b1;
                end else begin
                    pend_nxt[k]  = 1'b1;
                    ptype_nxt[k] = pressed[k];
                end
            end else if (svc_mask[k]) begin
                pend_nxt[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            key_held <= '0;
            pend     <= '0;
            ptype    <= '0;
            rr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            armed    <= 1'b1;
            key_held <= pressed;
            pend     <= pend_nxt;
            ptype    <= ptype_nxt;
            rr_ptr   <= rr_nxt;
            if (cancel) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    key_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_evt),
        .pop       (ev_ready),
        .head      (head),
        .valid     (ev_valid),
        .count     (fifo_count)
    );

    assign ev_press = head.press;
    assign ev_key   = head.key;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder: a per-cycle vector table for the
// single-event paths plus hand-written sequences for fill, cancel and reset.
module tb_key_event_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_in;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_press;
    logic [2:0] ev_key;
    logic [7:0] key_held;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] key_in;
        logic       ready;
        logic       exp_valid;
        logic       exp_press;
        logic [2:0] exp_key;
        logic [3:0] exp_count;
    } vec_t;

    vec_t vecs [24];

    key_event_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_press   (ev_press),
        .ev_key     (ev_key),
        .key_held   (key_held),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        key_in   = v.key_in;
        ev_ready = v.ready;
        step();
    endtask

    // Wait (bounded) for a head event, check it, then let it pop.
    task automatic expectEvent(input string name, input logic p, input logic [2:0] k);
        int n = 0;
        while (!ev_valid && n < 12) begin
            step();
            n++;
        end
        checkOutput({name, "_valid"}, 32'(ev_valid), 32'd1);
        if (ev_valid) begin
            checkOutput({name, "_press"}, 32'(ev_press), 32'(p));
            checkOutput({name, "_key"}, 32'(ev_key), 32'(k));
        end
        step();
    endtask

    initial begin
        vecs[0]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[1]  = '{8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 4'd1};
        vecs[2]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[3]  = '{8'hF7, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[4]  = '{8'hF7, 1'b1, 1'b1, 1'b1, 3'd3, 4'd1};
        vecs[5]  = '{8'hF7, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[6]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[7]  = '{8'hFF, 1'b1, 1'b1, 1'b0, 3'd3, 4'd1};
        vecs[8]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[9]  = '{8'hFE, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[10] = '{8'hFE, 1'b1, 1'b1, 1'b1, 3'd0, 4'd1};
        vecs[11] = '{8'hFE, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[12] = '{8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[13] = '{8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 4'd1};
        vecs[14] = '{8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[15] = '{8'hAD, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[16] = '{8'hAD, 1'b1, 1'b1, 1'b1, 3'd1, 4'd1};
        vecs[17] = '{8'hAD, 1'b1, 1'b1, 1'b1, 3'd4, 4'd1};
        vecs[18] = '{8'hAD, 1'b1, 1'b1, 1'b1, 3'd6, 4'd1};
        vecs[19] = '{8'hAD, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[20] = '{8'h29, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};
        vecs[21] = '{8'h29, 1'b1, 1'b1, 1'b1, 3'd7, 4'd1};
        vecs[22] = '{8'h29, 1'b1, 1'b1, 1'b1, 3'd2, 4'd1};
        vecs[23] = '{8'h29, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0};

        rst_n    = 1'b0;
        key_in   = 8'hFE;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        #2;
        checkOutput("rst_valid", 32'(ev_valid), 32'd0);
        checkOutput("rst_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_held", 32'(key_held), 32'h00);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);

        step(2);
        rst_n = 1'b1;
        step(3);
        checkOutput("arm_valid", 32'(ev_valid), 32'd0);
        checkOutput("arm_held", 32'(key_held), 32'h01);
        checkOutput("arm_ovf", 32'(overflow), 32'd0);
        checkOutput("arm_count", 32'(fifo_count), 32'd0);

        // Single events, latency, round-robin order with ready held high.
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_valid", i), 32'(ev_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d_press", i), 32'(ev_press), 32'(vecs[i].exp_press));
                checkOutput($sformatf("vec%0d_key", i), 32'(ev_key), 32'(vecs[i].exp_key));
            end
        end

        // Release keys 1,2,4,6,7 together; arbitration resumes at key 3.
        key_in = 8'hFF;
        expectEvent("rel4", 1'b0, 3'd4);
        expectEvent("rel6", 1'b0, 3'd6);
        expectEvent("rel7", 1'b0, 3'd7);
        expectEvent("rel1", 1'b0, 3'd1);
        expectEvent("rel2", 1'b0, 3'd2);
        step(2);
        checkOutput("rel_empty", 32'(fifo_count), 32'd0);

        // Ten edges with the consumer stalled: eight queued, two held pending.
        ev_ready = 1'b0;
        key_in   = 8'h00;
        step(12);
        checkOutput("full_count", 32'(fifo_count), 32'd8);
        key_in = 8'h18;
        step(3);
        checkOutput("full_count2", 32'(fifo_count), 32'd8);
        checkOutput("full_ovf", 32'(overflow), 32'd0);
        checkOutput("full_head_key", 32'(ev_key), 32'd3);
        ev_ready = 1'b1;
        expectEvent("d0", 1'b1, 3'd3);
        expectEvent("d1", 1'b1, 3'd4);
        expectEvent("d2", 1'b1, 3'd5);
        expectEvent("d3", 1'b1, 3'd6);
        expectEvent("d4", 1'b1, 3'd7);
        expectEvent("d5", 1'b1, 3'd0);
        expectEvent("d6", 1'b1, 3'd1);
        expectEvent("d7", 1'b1, 3'd2);
        expectEvent("d8", 1'b0, 3'd3);
        expectEvent("d9", 1'b0, 3'd4);
        step(2);
        checkOutput("drain_count", 32'(fifo_count), 32'd0);
        checkOutput("drain_valid", 32'(ev_valid), 32'd0);

        // Refill, then toggle key 5 twice while it cannot be serviced.
        ev_ready = 1'b0;
        key_in   = 8'hFF;
        step(10);
        key_in = 8'hE7;
        step(5);
        checkOutput("ref_count", 32'(fifo_count), 32'd8);
        key_in = 8'hC7;
        step();
        key_in = 8'hE7;
        step();
        checkOutput("cancel_ovf", 32'(overflow), 32'd1);
        checkOutput("cancel_count", 32'(fifo_count), 32'd8);
        step(2);
        checkOutput("cancel_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checkOutput("ovf_clr", 32'(overflow), 32'd0);
        ev_ready = 1'b1;
        expectEvent("c0", 1'b0, 3'd5);
        expectEvent("c1", 1'b0, 3'd6);
        expectEvent("c2", 1'b0, 3'd7);
        expectEvent("c3", 1'b0, 3'd0);
        expectEvent("c4", 1'b0, 3'd1);
        expectEvent("c5", 1'b0, 3'd2);
        expectEvent("c6", 1'b1, 3'd3);
        expectEvent("c7", 1'b1, 3'd4);
        step(3);
        checkOutput("cancel_none", 32'(ev_valid), 32'd0);
        checkOutput("cancel_empty", 32'(fifo_count), 32'd0);

        // Asynchronous reset in mid-cycle with four events queued.
        ev_ready = 1'b0;
        key_in   = 8'hFC;
        step(8);
        checkOutput("pre_rst_count", 32'(fifo_count), 32'd4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", 32'(ev_valid), 32'd0);
        checkOutput("async_count", 32'(fifo_count), 32'd0);
        checkOutput("async_held", 32'(key_held), 32'h00);
        step(2);
        rst_n = 1'b1;
        step(5);
        checkOutput("post_rst_valid", 32'(ev_valid), 32'd0);
        checkOutput("post_rst_count", 32'(fifo_count), 32'd0);
        checkOutput("post_rst_held", 32'(key_held), 32'h03);
        checkOutput("post_rst_ovf", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
